// File: rtl/mm_iddmm_collect_if.sv
// Result stream from the IDDMM collector to its consumer: valid/ready with a
// last-word marker and the word index. master = collector, slave = consumer.
interface mm_iddmm_collect_if #(
  parameter int unsigned K      = 128,
  parameter int unsigned ADDR_W = 5
);
  logic [K-1:0]      out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic [ADDR_W-1:0] out_idx;

  modport master (
    output out_data,
    output out_valid,
    output out_last,
    output out_idx,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_last,
    input  out_idx,
    output out_ready
  );
endinterface

// File: rtl/mm_iddmm_collect.sv
// IDDMM result collector: buffers K-bit words from the subtract stage, then replays them
// over a valid/ready stream. Define MM_IDDMM_COLLECT_MSW_FIRST_EN to replay highest index first.
module mm_iddmm_collect #(
  parameter int unsigned K      = 128,
  parameter int unsigned N      = 32,
  parameter int unsigned ADDR_W = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [K-1:0]         i_res,
  input  logic                 i_res_val,
  input  logic                 i_task_end,
  mm_iddmm_collect_if.master   o_out,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_short_err,
  output logic                 o_ovf_err
);

  localparam int unsigned WCNT_W = ADDR_W + 1;
  localparam logic [WCNT_W-1:0] WCNT_FULL = WCNT_W'(N);
  localparam logic [WCNT_W-1:0] WCNT_ONE  = WCNT_W'(1);
  localparam logic [ADDR_W-1:0] IDX_ONE   = ADDR_W'(1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] SEND    = 2'd2;

`ifdef MM_IDDMM_COLLECT_MSW_FIRST_EN
  localparam logic MSW_FIRST = 1'b1;
`else
  localparam logic MSW_FIRST = 1'b0;
`endif

  logic [K-1:0]        r_buf [N];
  logic [1:0]          r_state;
  logic [WCNT_W-1:0]   r_wcnt;
  logic [K-1:0]        r_out_data;
  logic                r_valid;
  logic                r_last;
  logic [ADDR_W-1:0]   r_idx;
  logic                r_done;
  logic                r_short;
  logic                r_ovf;

  logic [1:0]          w_state_nxt;
  logic [WCNT_W-1:0]   w_wcnt_nxt;
  logic                w_wr_en;
  logic [ADDR_W-1:0]   w_wr_idx;
  logic                w_load;
  logic [ADDR_W-1:0]   w_first_idx;
  logic [K-1:0]        w_data_nxt;
  logic                w_valid_nxt;
  logic                w_last_nxt;
  logic [ADDR_W-1:0]   w_idx_nxt;
  logic                w_done_nxt;
  logic                w_short_nxt;
  logic                w_ovf_nxt;
  logic [ADDR_W-1:0]   w_step_idx;
  logic [ADDR_W-1:0]   w_last_idx;
  logic                w_hs;

  assign w_hs       = r_valid & o_out.out_ready;
  assign w_step_idx = MSW_FIRST ? (r_idx - IDX_ONE) : (r_idx + IDX_ONE);
  assign w_last_idx = MSW_FIRST ? '0 : ADDR_W'(r_wcnt - WCNT_ONE);

  always_comb begin
    w_state_nxt = r_state;
    w_wcnt_nxt  = r_wcnt;
    w_wr_en     = 1'b0;
    w_wr_idx    = r_wcnt[ADDR_W-1:0];
    w_load      = 1'b0;
    w_first_idx = '0;
    w_data_nxt  = r_out_data;
    w_valid_nxt = r_valid;
    w_last_nxt  = r_last;
    w_idx_nxt   = r_idx;
    w_done_nxt  = 1'b0;
    w_short_nxt = r_short;
    w_ovf_nxt   = r_ovf;

    unique case (r_state)
      IDLE: begin
        if (i_res_val) begin
          w_wr_en     = 1'b1;
          w_wr_idx    = '0;
          w_wcnt_nxt  = WCNT_ONE;
          w_short_nxt = 1'b0;
          w_ovf_nxt   = 1'b0;
          if (i_task_end) begin
            w_state_nxt = SEND;
            w_load      = 1'b1;
          end else begin
            w_state_nxt = COLLECT;
          end
        end else if (i_task_end) begin
          w_done_nxt = 1'b1;
        end
      end
      COLLECT: begin
        if (i_res_val) begin
          if (r_wcnt < WCNT_FULL) begin
            w_wr_en    = 1'b1;
            w_wcnt_nxt = r_wcnt + WCNT_ONE;
          end else begin
            w_ovf_nxt = 1'b1;
          end
        end
        if (i_task_end) begin
          w_state_nxt = SEND;
          w_load      = 1'b1;
        end
      end
      SEND: begin
        if (i_res_val) w_ovf_nxt = 1'b1;
        if (w_hs) begin
          if (r_last) begin
            w_state_nxt = IDLE;
            w_valid_nxt = 1'b0;
            w_last_nxt  = 1'b0;
            w_wcnt_nxt  = '0;
            w_done_nxt  = 1'b1;
          end else begin
            w_idx_nxt  = w_step_idx;
            w_data_nxt = r_buf[w_step_idx];
            w_last_nxt = (w_step_idx == w_last_idx);
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    // First word may be the one written this very cycle, so forward it around the buffer.
    if (w_load) begin
      w_first_idx = MSW_FIRST ? ADDR_W'(w_wcnt_nxt - WCNT_ONE) : '0;
      w_idx_nxt   = w_first_idx;
      w_valid_nxt = 1'b1;
      w_last_nxt  = (w_wcnt_nxt == WCNT_ONE);
      w_data_nxt  = (w_wr_en && (w_wr_idx == w_first_idx)) ? i_res : r_buf[w_first_idx];
      if (w_wcnt_nxt < WCNT_FULL) w_short_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) r_buf[w_wr_idx] <= i_res;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_wcnt     <= '0;
      r_out_data <= '0;
      r_valid    <= 1'b0;
      r_last     <= 1'b0;
      r_idx      <= '0;
      r_done     <= 1'b0;
      r_short    <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wcnt     <= w_wcnt_nxt;
      r_out_data <= w_data_nxt;
      r_valid    <= w_valid_nxt;
      r_last     <= w_last_nxt;
      r_idx      <= w_idx_nxt;
      r_done     <= w_done_nxt;
      r_short    <= w_short_nxt;
      r_ovf      <= w_ovf_nxt;
    end
  end

  assign o_out.out_data  = r_out_data;
  assign o_out.out_valid = r_valid;
  assign o_out.out_last  = r_last;
  assign o_out.out_idx   = r_idx;
  assign o_busy          = (r_state != IDLE);
  assign o_done          = r_done;
  assign o_short_err     = r_short;
  assign o_ovf_err       = r_ovf;

endmodule

// File: tb/tb_mm_iddmm_collect.sv
// Scoreboard bench for mm_iddmm_collect: expected words are queued when task_end is driven
// and checked against every valid output cycle; popped on handshake.
module tb_mm_iddmm_collect;
  localparam int unsigned K      = 128;
  localparam int unsigned N      = 32;
  localparam int unsigned ADDR_W = 5;
`ifdef MM_IDDMM_COLLECT_MSW_FIRST_EN
  localparam bit MSW_FIRST = 1'b1;
`else
  localparam bit MSW_FIRST = 1'b0;
`endif

  typedef struct {
    logic [K-1:0]      data;
    logic [ADDR_W-1:0] idx;
    logic              last;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic [K-1:0] i_res;
  logic         i_res_val;
  logic         i_task_end;
  logic         o_busy;
  logic         o_done;
  logic         o_short_err;
  logic         o_ovf_err;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb_q[$];

  mm_iddmm_collect_if #(.K(K), .ADDR_W(ADDR_W)) bus ();

  mm_iddmm_collect #(.K(K), .N(N), .ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_res       (i_res),
    .i_res_val   (i_res_val),
    .i_task_end  (i_task_end),
    .o_out       (bus.master),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_short_err (o_short_err),
    .o_ovf_err   (o_ovf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [K-1:0] base, input int n);
    for (int k = 0; k < n; k++) begin
      exp_t e;
      int   ix;
      ix     = MSW_FIRST ? (n - 1 - k) : k;
      e.data = base + K'(ix);
      e.idx  = ADDR_W'(ix);
      e.last = (k == n - 1);
      sb_q.push_back(e);
    end
  endtask

  // Words first..n-1 of a result starting at base; task_end with last word or one cycle later.
  task automatic send_words(input logic [K-1:0] base, input int n, input int first,
                            input bit end_with_last);
    for (int i = first; i < n; i++) begin
      i_res     = base + K'(i);
      i_res_val = 1'b1;
      if (end_with_last && i == n - 1) begin
        i_task_end = 1'b1;
        push_exp(base, n);
      end
      tick();
    end
    i_res_val  = 1'b0;
    i_task_end = 1'b0;
    if (!end_with_last) begin
      i_task_end = 1'b1;
      push_exp(base, n);
      tick();
      i_task_end = 1'b0;
    end
  endtask

  // mode 0: ready held high; mode 1: ready pattern 1,0,0,1. inject: res_val pulses during SEND.
  task automatic drain(input int mode, input int inject, output int vcnt);
    int c;
    bit seen;
    c    = 0;
    seen = 1'b0;
    vcnt = 0;
    while (!seen && c < 300) begin
      bus.out_ready = (mode == 0) ? 1'b1 : ((c % 4 == 0) || (c % 4 == 3));
      if (c < inject) begin
        i_res_val = 1'b1;
        i_res     = K'(128'hdead_0000) + K'(c);
      end else begin
        i_res_val = 1'b0;
      end
      @(negedge clk);
      if (o_done) seen = 1'b1;
      else if (bus.out_valid) vcnt++;
      tick();
      c++;
    end
    i_res_val     = 1'b0;
    bus.out_ready = 1'b1;
    check("done_seen", 128'(seen), 128'(1));
    check("sb_drained", 128'(sb_q.size()), 128'(0));
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.out_valid) begin
      check("sb_nonempty", 128'(sb_q.size() != 0), 128'(1));
      if (sb_q.size() != 0) begin
        check("out_data", 128'(bus.out_data), 128'(sb_q[0].data));
        check("out_idx", 128'(bus.out_idx), 128'(sb_q[0].idx));
        check("out_last", 128'(bus.out_last), 128'(sb_q[0].last));
        if (bus.out_ready) void'(sb_q.pop_front());
      end
    end
  end

  initial begin
    int vcnt;
    bit hit;
    rst_n         = 1'b0;
    i_res         = '0;
    i_res_val     = 1'b0;
    i_task_end    = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) tick();
    check("rst_valid", 128'(bus.out_valid), 128'(0));
    check("rst_data", 128'(bus.out_data), 128'(0));
    check("rst_idx", 128'(bus.out_idx), 128'(0));
    check("rst_last", 128'(bus.out_last), 128'(0));
    check("rst_busy", 128'(o_busy), 128'(0));
    check("rst_done", 128'(o_done), 128'(0));
    check("rst_flags", 128'({o_short_err, o_ovf_err}), 128'(0));
    rst_n = 1'b1;
    tick();

    // Full result, ready high: valid for N cycles right after task_end, then done.
    send_words(K'(128'h1000), N, 0, 1'b1);
    check("first_valid", 128'(bus.out_valid), 128'(1));
    check("first_data", 128'(bus.out_data), MSW_FIRST ? 128'h101F : 128'h1000);
    check("busy_send", 128'(o_busy), 128'(1));
    drain(0, 0, vcnt);
    check("valid_cycles", 128'(vcnt), 128'(N));
    check("flags_full", 128'({o_short_err, o_ovf_err}), 128'(0));
    check("busy_after", 128'(o_busy), 128'(0));

    // Same with a stalling consumer.
    send_words(K'(128'h1000), N, 0, 1'b1);
    drain(1, 0, vcnt);
    check("flags_stall", 128'({o_short_err, o_ovf_err}), 128'(0));

    // Short result.
    send_words(K'(128'h2000), 20, 0, 1'b0);
    drain(0, 0, vcnt);
    check("short_cycles", 128'(vcnt), 128'(20));
    check("short_err", 128'(o_short_err), 128'(1));
    check("ovf_short", 128'(o_ovf_err), 128'(0));

    // Words arriving during SEND are dropped and flagged.
    send_words(K'(128'h3000), N, 0, 1'b1);
    drain(0, 3, vcnt);
    check("ovf_cycles", 128'(vcnt), 128'(N));
    check("ovf_err", 128'(o_ovf_err), 128'(1));
    check("short_clr", 128'(o_short_err), 128'(0));
    i_res     = K'(128'h4000);
    i_res_val = 1'b1;
    tick();
    i_res_val = 1'b0;
    check("ovf_clr", 128'(o_ovf_err), 128'(0));
    check("busy_coll", 128'(o_busy), 128'(1));
    send_words(K'(128'h4000), N, 1, 1'b1);
    drain(0, 0, vcnt);
    check("ovf_stays_clr", 128'(o_ovf_err), 128'(0));

    // task_end alone in IDLE.
    i_task_end = 1'b1;
    tick();
    i_task_end = 1'b0;
    @(negedge clk);
    check("lone_done", 128'(o_done), 128'(1));
    check("lone_valid", 128'(bus.out_valid), 128'(0));
    tick();
    @(negedge clk);
    check("lone_done_pulse", 128'(o_done), 128'(0));
    tick();

    // Asynchronous reset while index 10 is presented.
    send_words(K'(128'h5000), N, 0, 1'b1);
    hit = 1'b0;
    for (int c = 0; c < 100 && !hit; c++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_idx == ADDR_W'(10)) hit = 1'b1;
      else tick();
    end
    check("idx10_seen", 128'(hit), 128'(1));
    #1 rst_n = 1'b0;
    #1;
    sb_q.delete();
    check("mid_rst_valid", 128'(bus.out_valid), 128'(0));
    check("mid_rst_data", 128'(bus.out_data), 128'(0));
    check("mid_rst_idx", 128'(bus.out_idx), 128'(0));
    check("mid_rst_busy", 128'(o_busy), 128'(0));
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_valid", 128'(bus.out_valid), 128'(0));
    check("post_rst_flags", 128'({o_short_err, o_ovf_err, o_done}), 128'(0));
    send_words(K'(128'h6000), N, 0, 1'b1);
    drain(0, 0, vcnt);
    check("post_rst_cycles", 128'(vcnt), 128'(N));

    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mm_iddmm_collect.md
# mm_iddmm_collect

Result collector at the output end of the IDDMM compare-and-subtract stage. It captures the K-bit result words that the subtract stage streams out low word first, gated only by a valid strobe with no backpressure, into an internal N-word buffer. When the stage signals task end, it replays the whole result to a downstream consumer over a valid/ready handshake with a last-word marker. The subtract stage is always accepted at full rate; anything arriving while the buffer is being drained is dropped and flagged.

## Interface
- K, 128, word width; K<=128, power of two
- N, 32, words per result; N<=32, power of two
- ADDR_W, $clog2(N), buffer index width
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- res  in  K  result word from subtract stage
- res_val  in  1  res valid this cycle; words arrive index 0 upward
- task_end  in  1  one-cycle pulse, end of result; may coincide with the last res_val
- out_data  out  K  result word to consumer; reset 0
- out_valid  out  1  out_data valid; reset 0
- out_ready  in  1  consumer accepts out_data
- out_last  out  1  qualifies the final word of a result; reset 0
- out_idx  out  ADDR_W  word index of out_data; reset 0
- busy  out  1  high in COLLECT or SEND; reset 0
- done  out  1  one-cycle pulse after the final handshake, or after an empty task_end; reset 0
- short_err  out  1  sticky: task_end came with fewer than N words; reset 0
- ovf_err  out  1  sticky: a word was dropped; reset 0

## Operation
- States: IDLE, COLLECT, SEND.
- IDLE:
  - res_val: write res to buf[0], wcnt<=1, clear short_err and ovf_err, go to COLLECT.
  - task_end together with res_val: capture that word, then go directly to SEND with wcnt=1.
  - task_end alone: done pulse, stay in IDLE.
- COLLECT:
  - res_val with wcnt<N: buf[wcnt]<=res, wcnt++.
  - res_val with wcnt==N: word dropped, ovf_err<=1.
  - task_end: capture any same-cycle word first, then go to SEND.
  - short_err<=1 if the final wcnt<N.
- SEND:
  - Present wcnt words in order, one per handshake (out_valid & out_ready).
  - out_last=1 on the final word.
  - On the final handshake: go to IDLE, done pulses the next cycle, wcnt<=0.
- In SEND, res_val or task_end is ignored; ovf_err<=1 on res_val.
- The buffer is not cleared. Unwritten words are never presented because only wcnt words are sent.
- wcnt is ADDR_W+1 bits wide and saturates at N, so there is no wrap-around.

## Timing
- Capture: res_val at cycle t, and the word is in the buffer at t+1.
- task_end at cycle t:
  - state=SEND at t+1;
  - out_valid=1 with the first word at t+1.
  - Latency from task_end to first word is 1 cycle.
- out_data, out_idx and out_last are registered. They hold stable while out_valid & ~out_ready.
- out_valid never drops before its handshake.
- Zero-wait throughput is one word per cycle when out_ready is held high.
- Full N-word result with out_ready=1: out_valid is high for N cycles, t+1..t+N; done at t+N+1.
- busy falls in the cycle after the final handshake.
- A new res_val is accepted in that same cycle (IDLE).
- Reset mid-operation, asynchronous:
  - state<=IDLE, wcnt<=0, all outputs to their reset values, flags cleared.
  - A partially sent result is abandoned and not resumed.

## Configuration
- MM_IDDMM_COLLECT_MSW_FIRST_EN defined: SEND presents the highest captured index first (wcnt-1 down to 0). out_last goes on index 0, and out_idx counts down.
- Not defined: SEND presents index 0 first, up to wcnt-1. out_last goes on index wcnt-1.
- Capture order, flags and latency are identical in both builds.

## Test plan
- K=128, N=32: 32 consecutive res_val words of value 0x1000+i, with task_end on the 32nd word and out_ready=1 → out_valid for 32 cycles starting 1 cycle after task_end; words 0x1000..0x101F; out_last on idx 31; done one cycle later; no flags.
- Same stimulus with out_ready toggling 1,0,0,1 → each word held stable through the stall; all 32 delivered in order; no duplicates.
- 20 words, then task_end → 20 words sent; out_last on idx 19; short_err=1.
- A full result, then 3 res_val pulses during SEND → those 3 words are not sent; ovf_err=1; the sent data is unchanged. The next collection clears ovf_err on its first word.
- task_end alone in IDLE → done pulse, out_valid stays 0.
- rst_n low for 1 cycle while idx 10 is being presented → all outputs 0, state IDLE. A following 32-word result is collected and sent correctly.
- MSW_FIRST build, 32 words 0x1000+i → first out_data 0x101F with idx 31; out_last with idx 0.
